seg_display_scan: RTL and testbench

Eight-digit seven-segment display driver fed by the frequency divider's `clk_1khz` and `clk_5sec` toggle outputs. It latches a 128-bit AES block and shows it 32 bits (one page, 8 hex digits) at a time. Digits are multiplexed at the 1 kHz rate, and the page advances on each `clk_5sec` rising edge. All logic runs on the system clock; the divider outputs are used as edge-detected enables, never as clocks.

---
 rtl/seg_display_scan.sv | 124 ++++++++++++
 tb/tb_seg_display_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - eight-digit seven-segment scanner paging through a latched 128-bit block
// Divider toggles are edge-detected in the clk domain; an/seg/dp are registered from current state.
module seg_display_scan #(
  parameter int DIGITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_1khz,
  input  logic              clk_5sec,
  input  logic [127:0]      data_in,
  input  logic              data_valid,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [1:0]        page
);

  logic              prev_1k_q, prev_1k_d;
  logic              prev_5s_q, prev_5s_d;
  logic [2:0]        digit_q, digit_d;
  logic [1:0]        page_q, page_d;
  logic [127:0]      hold_q, hold_d;
  logic              loaded_q, loaded_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic        scan_tick;
  logic        page_tick;
  logic [31:0] word;
  logic [3:0]  nibble;
  logic [6:0]  seg_dec;

  always_comb begin
    prev_1k_d = clk_1khz;
    prev_5s_d = clk_5sec;
    scan_tick = (clk_1khz != prev_1k_q);
    page_tick = clk_5sec & ~prev_5s_q;

    digit_d  = digit_q;
    page_d   = page_q;
    hold_d   = hold_q;
    loaded_d = loaded_q;

    if (scan_tick) digit_d = digit_q + 3'd1;

    // A new block always restarts at page 0, even against a coincident page tick.
    if (data_valid) begin
      hold_d   = data_in;
      loaded_d = 1'b1;
      page_d   = 2'd0;
    end else if (page_tick) begin
      page_d = page_q + 2'd1;
    end

    case (page_q)
      2'd0:    word = hold_q[127:96];
      2'd1:    word = hold_q[95:64];
      2'd2:    word = hold_q[63:32];
      default: word = hold_q[31:0];
    endcase
    nibble = word[{digit_q, 2'b00} +: 4];

    case (nibble)
      4'h0:    seg_dec = 7'h40;
      4'h1:    seg_dec = 7'h79;
      4'h2:    seg_dec = 7'h24;
      4'h3:    seg_dec = 7'h30;
      4'h4:    seg_dec = 7'h19;
      4'h5:    seg_dec = 7'h12;
      4'h6:    seg_dec = 7'h02;
      4'h7:    seg_dec = 7'h78;
      4'h8:    seg_dec = 7'h00;
      4'h9:    seg_dec = 7'h10;
      4'hA:    seg_dec = 7'h08;
      4'hB:    seg_dec = 7'h03;
      4'hC:    seg_dec = 7'h46;
      4'hD:    seg_dec = 7'h21;
      4'hE:    seg_dec = 7'h06;
      default: seg_dec = 7'h0E;
    endcase

    if (loaded_q) begin
      an_d  = ~(DIGITS'(1) << digit_q);
      seg_d = seg_dec;
      dp_d  = (digit_q != {1'b0, page_q});
    end else begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  // Prev samples track the inputs through reset so no spurious tick follows release.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_1k_q <= clk_1khz;
      prev_5s_q <= clk_5sec;
      digit_q   <= 3'd0;
      page_q    <= 2'd0;
      hold_q    <= '0;
      loaded_q  <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      prev_1k_q <= prev_1k_d;
      prev_5s_q <= prev_5s_d;
      digit_q   <= digit_d;
      page_q    <= page_d;
      hold_q    <= hold_d;
      loaded_q  <= loaded_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign page = page_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - directed bench for seg_display_scan
module tb_seg_display_scan;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clk_1khz = 1'b1;
  logic         clk_5sec = 1'b0;
  logic [127:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic [7:0]   an;
  logic [6:0]   seg;
  logic         dp;
  logic [1:0]   page;

  int checks = 0;
  int failures = 0;

  logic [6:0]   seg_tab [16];
  logic [127:0] vec;

  seg_display_scan #(.DIGITS(8)) dut (
    .clk(clk), .rst(rst), .clk_1khz(clk_1khz), .clk_5sec(clk_5sec),
    .data_in(data_in), .data_valid(data_valid),
    .an(an), .seg(seg), .dp(dp), .page(page)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] d);
    data_in = d;
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_1khz = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    checks++; if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || page !== 2'd0) begin
      failures++; $display("FAIL reset_state an=%h seg=%h dp=%b page=%0d exp FF/7F/1/0", an, seg, dp, page); end
    // eight toggles bring the digit back to 0 provided no tick fired right after reset
    for (int i = 0; i < 8; i++) begin
      clk_1khz = ~clk_1khz;
      cyc();
      cyc();
      checks++; if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || page !== 2'd0) begin
        failures++; $display("FAIL blank_scan%0d an=%h seg=%h dp=%b page=%0d exp FF/7F/1/0", i, an, seg, dp, page); end
    end
  endtask

  task automatic test_load_scan();
    load(vec);
    checks++; if (an !== 8'hFE || seg !== 7'h78 || dp !== 1'b0) begin
      failures++; $display("FAIL load_digit0 an=%h seg=%h dp=%b exp FE/78/0", an, seg, dp); end
    clk_1khz = ~clk_1khz;
    cyc();
    cyc();
    checks++; if (an !== 8'hFD || seg !== 7'h02 || dp !== 1'b1) begin
      failures++; $display("FAIL scan_digit1 an=%h seg=%h dp=%b exp FD/02/1", an, seg, dp); end
    // back-to-back transitions on consecutive cycles
    for (int i = 0; i < 7; i++) begin
      clk_1khz = ~clk_1khz;
      cyc();
    end
    cyc();
    checks++; if (an !== 8'hFE || seg !== 7'h78) begin
      failures++; $display("FAIL scan_wrap an=%h seg=%h exp FE/78", an, seg); end
  endtask

  task automatic test_page_advance();
    logic [1:0] exp_page [3];
    logic [6:0] exp_seg [3];
    exp_page[0] = 2'd2; exp_page[1] = 2'd3; exp_page[2] = 2'd0;
    exp_seg[0] = 7'h00; exp_seg[1] = 7'h40; exp_seg[2] = 7'h78;
    clk_5sec = 1'b1;
    cyc();
    cyc();
    checks++; if (page !== 2'd1 || seg !== 7'h0E || an !== 8'hFE || dp !== 1'b1) begin
      failures++; $display("FAIL page1 page=%0d seg=%h an=%h dp=%b exp 1/0E/FE/1", page, seg, an, dp); end
    clk_5sec = 1'b0;
    cyc();
    cyc();
    checks++; if (page !== 2'd1 || seg !== 7'h0E) begin
      failures++; $display("FAIL page_fall page=%0d seg=%h exp 1/0E", page, seg); end
    for (int i = 0; i < 3; i++) begin
      clk_5sec = 1'b1;
      cyc();
      clk_5sec = 1'b0;
      cyc();
      checks++; if (page !== exp_page[i] || seg !== exp_seg[i]) begin
        failures++; $display("FAIL page_step%0d page=%0d seg=%h exp %0d/%h", i, page, seg, exp_page[i], exp_seg[i]); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 2; i++) begin
      clk_5sec = 1'b1;
      cyc();
      clk_5sec = 1'b0;
      cyc();
    end
    checks++; if (page !== 2'd2) begin
      failures++; $display("FAIL sim_setup page=%0d exp 2", page); end
    data_in = '1;
    data_valid = 1'b1;
    clk_5sec = 1'b1;
    cyc();
    data_valid = 1'b0;
    cyc();
    checks++; if (page !== 2'd0 || seg !== 7'h0E) begin
      failures++; $display("FAIL sim_event page=%0d seg=%h exp 0/0E", page, seg); end
    clk_5sec = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (seg !== 7'h0E || an !== ~(8'd1 << i)) begin
        failures++; $display("FAIL sim_digit%0d seg=%h an=%h exp 0E/%h", i, seg, an, ~(8'd1 << i)); end
      clk_1khz = ~clk_1khz;
      cyc();
      cyc();
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 5; i++) begin
      clk_1khz = ~clk_1khz;
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      clk_5sec = 1'b1;
      cyc();
      clk_5sec = 1'b0;
      cyc();
    end
    checks++; if (an !== 8'hDF || page !== 2'd2) begin
      failures++; $display("FAIL mid_setup an=%h page=%0d exp DF/2", an, page); end
    rst = 1'b1;
    data_in = vec;
    data_valid = 1'b1;
    cyc();
    rst = 1'b0;
    data_valid = 1'b0;
    checks++; if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || page !== 2'd0) begin
      failures++; $display("FAIL mid_reset an=%h seg=%h dp=%b page=%0d exp FF/7F/1/0", an, seg, dp, page); end
    cyc();
    checks++; if (an !== 8'hFF || seg !== 7'h7F) begin
      failures++; $display("FAIL mid_blank an=%h seg=%h exp FF/7F", an, seg); end
    load(vec);
    checks++; if (an !== 8'hFE || seg !== 7'h78 || dp !== 1'b0) begin
      failures++; $display("FAIL mid_reload an=%h seg=%h dp=%b exp FE/78/0", an, seg, dp); end
  endtask

  task automatic test_decode_sweep();
    logic [31:0] w;
    for (int p = 0; p < 2; p++) begin
      w = (p == 0) ? 32'h01234567 : 32'h89ABCDEF;
      for (int i = 0; i < 8; i++) begin
        checks++; if (seg !== seg_tab[w[4*i +: 4]] || an !== ~(8'd1 << i) || dp !== (i != p)) begin
          failures++; $display("FAIL decode_p%0d_d%0d seg=%h an=%h dp=%b exp %h/%h/%b",
                               p, i, seg, an, dp, seg_tab[w[4*i +: 4]], ~(8'd1 << i), (i != p)); end
        clk_1khz = ~clk_1khz;
        cyc();
        cyc();
      end
      clk_5sec = 1'b1;
      cyc();
      clk_5sec = 1'b0;
      cyc();
    end
  endtask

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    vec = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    test_reset();
    test_load_scan();
    test_page_advance();
    test_simultaneous();
    test_reset_mid_scan();
    test_decode_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
